// File: rtl/pu_mult_pkg.sv
// pu_mult_pkg: shared widths, attribute index and operand select encoding for pu_mult.
package pu_mult_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ATTR_WIDTH_DEF = 4;
  localparam int INVALID_IDX = 0;
  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;
endpackage

// File: rtl/pu_mult_mult_core.sv
// mult_core: combinational signed W x W multiplier with full 2W-bit product.
module mult_core #(
  parameter int W = 32
) (
  input  logic signed [W-1:0]   a_i,
  input  logic signed [W-1:0]   b_i,
  output logic signed [2*W-1:0] p_o
);
  assign p_o = a_i * b_i;
endmodule

// File: rtl/pu_mult.sv
// pu_mult: signed multiplier processing unit with OR-combinable bus outputs.
// Define PU_MULT_OVERFLOW_EN to flag truncating products as invalid.
module pu_mult
  import pu_mult_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ATTR_WIDTH = ATTR_WIDTH_DEF,
  parameter int INVALID = INVALID_IDX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal_wr,
  input  logic                  signal_sel,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ATTR_WIDTH-1:0] attr_in,
  input  logic                  signal_oe,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out
);
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, prod_q, prod_d;
  logic [ATTR_WIDTH-1:0] attr_a_q, attr_a_d, attr_b_q, attr_b_d, rattr_q, rattr_d;
  logic start_q, start_d, wr_a, wr_b, ovf;
  logic signed [2*DATA_WIDTH-1:0] p;
  logic [DATA_WIDTH:0] p_hi;

  mult_core #(.W(DATA_WIDTH)) u_core (
    .a_i(a_q),
    .b_i(b_q),
    .p_o(p)
  );

  assign p_hi = p[2*DATA_WIDTH-1:DATA_WIDTH-1];
  // Product fits in DATA_WIDTH signed bits only when the top DATA_WIDTH+1 bits are a pure sign extension.
`ifdef PU_MULT_OVERFLOW_EN
  assign ovf = !((&p_hi) || !(|p_hi));
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    wr_a = signal_wr && sel_e'(signal_sel) == SEL_A;
    wr_b = signal_wr && sel_e'(signal_sel) == SEL_B;
    a_d = wr_a ? data_in : a_q;
    attr_a_d = wr_a ? attr_in : attr_a_q;
    b_d = wr_b ? data_in : b_q;
    attr_b_d = wr_b ? attr_in : attr_b_q;
    start_d = wr_b;
    prod_d = start_q ? p[DATA_WIDTH-1:0] : prod_q;
    rattr_d = rattr_q;
    if (start_q) begin
      rattr_d = '0;
      rattr_d[INVALID] = attr_a_q[INVALID] | attr_b_q[INVALID] | ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      attr_a_q <= '0;
      attr_b_q <= '0;
      prod_q <= '0;
      rattr_q <= '0;
      start_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      attr_a_q <= attr_a_d;
      attr_b_q <= attr_b_d;
      prod_q <= prod_d;
      rattr_q <= rattr_d;
      start_q <= start_d;
    end
  end

  assign data_out = signal_oe ? prod_q : '0;
  assign attr_out = signal_oe ? rattr_q : '0;
endmodule

// File: tb/tb_pu_mult.sv
// tb_pu_mult: table-driven, hand-written and randomized checks of pu_mult.
module tb_pu_mult;
  logic clk = 1'b0, rst = 1'b1, wr = 1'b0, sel = 1'b0, oe = 1'b0;
  logic [31:0] din = '0, dout;
  logic [3:0] ain = '0, aout;
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  aa;
    logic [31:0] b;
    logic [3:0]  ab;
    logic [31:0] ed;
    logic [3:0]  ea;
  } vec_t;
  vec_t vecs[8];

  pu_mult dut (
    .clk(clk), .rst(rst), .signal_wr(wr), .signal_sel(sel), .data_in(din),
    .attr_in(ain), .signal_oe(oe), .data_out(dout), .attr_out(aout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] aa, input logic [31:0] b, input logic [3:0] ab);
    @(negedge clk); wr = 1; sel = 0; din = a; ain = aa;
    @(negedge clk); sel = 1; din = b; ain = ab;
    @(negedge clk); wr = 0; sel = 0;
    @(negedge clk);
  endtask

  task automatic read(input string name, input logic [31:0] ed, input logic [3:0] ea);
    oe = 0; #1;
    check({name, " data oe0"}, dout, 32'h0);
    check({name, " attr oe0"}, {28'h0, aout}, 32'h0);
    oe = 1; #1;
    check({name, " data"}, dout, ed);
    check({name, " attr"}, {28'h0, aout}, {28'h0, ea});
    oe = 0;
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] aa,
                                input logic [3:0] ab, output logic [31:0] ed, output logic [3:0] ea);
    longint p;
    logic ovf;
    p = longint'($signed(a)) * longint'($signed(b));
    ed = p[31:0];
    ovf = p != longint'($signed(p[31:0]));
    ea = {3'b000, aa[0] | ab[0]};
`ifdef PU_MULT_OVERFLOW_EN
    ea[0] = ea[0] | ovf;
`else
    if (ovf) ea[0] = ea[0];
`endif
  endfunction

  initial begin
    logic [31:0] ed, ra, rb;
    logic [3:0] ea, raa, rab;
    vecs[0] = '{32'd5, 4'h0, 32'h00100007, 4'h0, 32'h00500023, 4'h0};
    vecs[1] = '{32'd4, 4'h0, 32'd5, 4'h0, 32'd20, 4'h0};
    vecs[2] = '{-32'sd10, 4'h0, -32'sd10, 4'h0, 32'd100, 4'h0};
    vecs[3] = '{32'h111, 4'h0, 32'h111, 4'h0, 32'h00012321, 4'h0};
    vecs[4] = '{32'd4, 4'h1, 32'd5, 4'h0, 32'd20, 4'h1};
    vecs[5] = '{32'd4, 4'h0, 32'd5, 4'h0, 32'd20, 4'h0};
    vecs[6] = '{-32'sd4, 4'h0, 32'd5, 4'h0, 32'hFFFFFFEC, 4'h0};
`ifdef PU_MULT_OVERFLOW_EN
    vecs[7] = '{32'h00010000, 4'h0, 32'h00010000, 4'h0, 32'h0, 4'h1};
`else
    vecs[7] = '{32'h00010000, 4'h0, 32'h00010000, 4'h0, 32'h0, 4'h0};
`endif
    oe = 1;
    repeat (2) @(negedge clk);
    check("reset data", dout, 32'h0);
    check("reset attr", {28'h0, aout}, 32'h0);
    rst = 0; oe = 0;
    load(vecs[0].a, vecs[0].aa, vecs[0].b, vecs[0].ab);
    oe = 1;
    for (int i = 0; i < 5; i++) begin
      #1 check("hold data", dout, 32'h00500023);
      check("hold attr", {28'h0, aout}, 32'h0);
      @(negedge clk);
    end
    oe = 0;
    for (int i = 1; i < 8; i++) begin
      load(vecs[i].a, vecs[i].aa, vecs[i].b, vecs[i].ab);
      read($sformatf("vec%0d", i), vecs[i].ed, vecs[i].ea);
    end
    load(32'd7, 4'h0, 32'd3, 4'h0);
    read("seed a", 32'd21, 4'h0);
    @(negedge clk); wr = 1; sel = 1; din = 32'd6; ain = 4'h0;
    @(negedge clk); wr = 0;
    @(negedge clk);
    read("reuse a", 32'd42, 4'h0);
    @(negedge clk); wr = 1; sel = 0; din = 32'd100; oe = 1; #1;
    check("wr+oe", dout, 32'd42);
    @(negedge clk); #1;
    check("wr a keeps result", dout, 32'd42);
    wr = 0; oe = 0;
    @(negedge clk); wr = 0; sel = 1; din = 32'd9;
    @(negedge clk); #1;
    check("sel ignored", dout, 32'd0);
    oe = 1; #1;
    check("sel ignored result", dout, 32'd42);
    oe = 0;
    @(negedge clk); wr = 1; sel = 0; din = 32'd3;
    @(negedge clk); sel = 1; din = 32'd9;
    @(negedge clk); wr = 0; rst = 1;
    @(negedge clk); rst = 0;
    @(negedge clk);
    read("reset abort", 32'd0, 4'h0);
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = (i % 2 == 0) ? $urandom : $urandom_range(0, 1000);
      raa = 4'($urandom); rab = 4'($urandom);
      model(ra, rb, raa, rab, ed, ea);
      load(ra, raa, rb, rab);
      read($sformatf("rand%0d", i), ed, ea);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
